// File: rtl/bit_changer_pkg.sv
// Shared definitions for index-taking ALU blocks: operation/state encodings and
// sign-magnitude index helpers (MSB = sign, remaining bits = magnitude).
package bit_changer_pkg;

  typedef enum logic [1:0] {
    MODE_SET       = 2'b00,
    MODE_CLR       = 2'b01,
    MODE_TOGGLE    = 2'b10,
    MODE_RANGE_SET = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Helpers operate on a zero-extended index so one set serves any width up to this.
  localparam int IDX_MAX_W = 32;

  function automatic logic idx_sign(input logic [IDX_MAX_W-1:0] x, input int n = 8);
    return ((x >> (n - 1)) & 32'd1) != 32'd0;
  endfunction

  function automatic logic [IDX_MAX_W-1:0] idx_mag(input logic [IDX_MAX_W-1:0] x, input int n = 8);
    return x & ((32'd1 << (n - 1)) - 32'd1);
  endfunction

  function automatic logic idx_err(input logic [IDX_MAX_W-1:0] x, input int n = 8);
    return idx_sign(x, n) || (idx_mag(x, n) >= $unsigned(n));
  endfunction

endpackage

// File: rtl/bit_op_unit.sv
// Combinational single-bit SET/CLR/TOGGLE on an operand; any other op passes
// the operand through unchanged.
module bit_op_unit
  import bit_changer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_a,
  input  logic [$clog2(N)-1:0] i_idx,
  input  mode_e                i_op,
  output logic [N-1:0]         o_res
);

  logic [N-1:0] w_mask;

  assign w_mask = {{(N-1){1'b0}}, 1'b1} << i_idx;

  always_comb begin
    o_res = i_a;
    unique case (i_op)
      MODE_SET:    o_res = i_a | w_mask;
      MODE_CLR:    o_res = i_a & ~w_mask;
      MODE_TOGGLE: o_res = i_a ^ w_mask;
      default:     o_res = i_a;
    endcase
  end

endmodule

// File: rtl/bit_changer_seq.sv
// Sequential bit manipulator: single-bit ops answer one cycle after accept,
// RANGE_SET walks one bit per cycle through a shared bit_op_unit.
module bit_changer_seq
  import bit_changer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  // Handshake: a request transfers on a rising edge where in_valid && o_ready;
  // o_valid is a one-cycle pulse with no backpressure, o_out/o_ERR hold until the next result.
  input  logic         in_valid,
  output logic         o_ready,
  input  logic [1:0]   in_mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  output logic         o_valid,
  output logic [N-1:0] o_out,
  output logic         o_ERR,
  output state_e       o_dbg_state
);

  localparam int CNT_W = $clog2(N);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [N-1:0]           r_work;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_hi;
  logic [N-1:0]           r_out;
  logic                   r_err;
  logic                   r_valid;

  mode_e                  w_mode;
  logic [IDX_MAX_W-1:0]   w_mag_b;
  logic [IDX_MAX_W-1:0]   w_mag_c;
  logic                   w_err_b;
  logic                   w_err_c;
  logic                   w_is_range;
  logic                   w_err;
  logic                   w_accept;
  logic                   w_start_range;
  logic                   w_last;
  logic [N-1:0]           w_op_a;
  logic [CNT_W-1:0]       w_op_idx;
  mode_e                  w_op_mode;
  logic [N-1:0]           w_op_res;

  assign w_mode     = mode_e'(in_mode);
  assign w_mag_b    = idx_mag(IDX_MAX_W'(in_b), N);
  assign w_mag_c    = idx_mag(IDX_MAX_W'(in_c), N);
  assign w_err_b    = idx_err(IDX_MAX_W'(in_b), N);
  assign w_err_c    = idx_err(IDX_MAX_W'(in_c), N);
  assign w_is_range = (w_mode == MODE_RANGE_SET);
  // in_c only matters for a range, so it is masked out of the error in other modes.
  assign w_err      = w_err_b | (w_is_range & (w_err_c | (w_mag_c < w_mag_b)));

  assign o_ready       = (r_state == ST_IDLE);
  assign w_accept      = in_valid & o_ready;
  assign w_start_range = w_accept & w_is_range & ~w_err;
  assign w_last        = (r_state == ST_RUN) && (r_cnt == r_hi);

  // The one bit_op_unit serves the request path in IDLE and the range walk in RUN.
  assign w_op_a    = (r_state == ST_RUN) ? r_work : in_a;
  assign w_op_idx  = (r_state == ST_RUN) ? r_cnt : w_mag_b[CNT_W-1:0];
  assign w_op_mode = (r_state == ST_RUN) ? MODE_SET : w_mode;

  bit_op_unit #(.N(N)) u_bit_op (
    .i_a   (w_op_a),
    .i_idx (w_op_idx),
    .i_op  (w_op_mode),
    .o_res (w_op_res)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start_range) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == ST_RUN) begin
        r_work <= w_op_res;
        if (w_last) begin
          r_out   <= w_op_res;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
        end else begin
          // Stops at mag(c), which is at most N-1, so the counter cannot wrap.
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_accept) begin
        if (w_start_range) begin
          r_work <= in_a;
          r_cnt  <= w_mag_b[CNT_W-1:0];
          r_hi   <= w_mag_c[CNT_W-1:0];
        end else begin
          r_out   <= w_err ? '0 : w_op_res;
          r_err   <= w_err;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_out       = r_out;
  assign o_ERR       = r_err;
  assign o_valid     = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bit_changer_seq.sv
// Bench for bit_changer_seq: vector table, hand-written range/reset sequences and
// random traffic, all checked through an expected-result queue.
module tb_bit_changer_seq;
  import bit_changer_pkg::*;

  localparam int N = 8;
  localparam int W = 16 + 1 + N;

  logic         in_clk = 1'b0;
  logic         in_rst_n;
  logic         in_valid;
  logic         o_ready;
  logic [1:0]   in_mode;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_c;
  logic         o_valid;
  logic [N-1:0] o_out;
  logic         o_ERR;
  state_e       o_dbg_state;

  bit_changer_seq #(.N(N)) dut (
    .in_clk      (in_clk),
    .in_rst_n    (in_rst_n),
    .in_valid    (in_valid),
    .o_ready     (o_ready),
    .in_mode     (in_mode),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_c        (in_c),
    .o_valid     (o_valid),
    .o_out       (o_out),
    .o_ERR       (o_ERR),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];   // {expected cycle[15:0], err, out}
  logic [W-1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge in_clk) begin
    if (in_rst_n === 1'b1 && o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out", 32'(o_out), 32'(mon_e[N-1:0]));
        chk("err", 32'(o_ERR), 32'(mon_e[N]));
        chk("latency", 32'(cyc[15:0]), 32'(mon_e[W-1:N+1]));
      end
    end
  end

  // Independent reference: sign-magnitude index decode and bit loop.
  function automatic void model(input logic [1:0] mode, input logic [N-1:0] a, b, c,
                                output logic [N-1:0] out, output logic err, output int lat);
    int mb;
    int mc;
    logic bad_b;
    logic bad_c;
    mb    = int'(b[N-2:0]);
    mc    = int'(c[N-2:0]);
    bad_b = b[N-1] || (mb >= N);
    bad_c = c[N-1] || (mc >= N);
    out   = a;
    err   = 1'b0;
    lat   = 1;
    if (bad_b || (mode == 2'b11 && (bad_c || mc < mb))) begin
      out = '0;
      err = 1'b1;
    end else begin
      case (mode)
        2'b00: out[mb] = 1'b1;
        2'b01: out[mb] = 1'b0;
        2'b10: out[mb] = ~out[mb];
        default: begin
          for (int i = mb; i <= mc; i++) out[i] = 1'b1;
          lat = mc - mb + 2;
        end
      endcase
    end
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] mode, input logic [N-1:0] a, b, c,
                      input logic [N-1:0] eo, input logic ee, input int lat);
    int budget;
    @(negedge in_clk);
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    budget   = 0;
    while (!o_ready && budget < 50) begin
      @(negedge in_clk);
      budget++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
    exp_q.push_back({16'(cyc + lat), ee, eo});
    @(posedge in_clk);
  endtask

  task automatic send_rand;
    logic [1:0]   m;
    logic [N-1:0] a, b, c, eo;
    logic         ee;
    int           lat;
    m = 2'($urandom_range(0, 3));
    a = N'($urandom_range(0, 255));
    b = ($urandom_range(0, 5) == 0) ? N'(8'h80 | $urandom_range(0, 7)) : N'($urandom_range(0, 8));
    c = ($urandom_range(0, 5) == 0) ? N'(8'h80 | $urandom_range(0, 7)) : N'($urandom_range(0, 8));
    model(m, a, b, c, eo, ee, lat);
    send(m, a, b, c, eo, ee, lat);
  endtask

  task automatic go_idle;
    @(negedge in_clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge in_clk);
      budget++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"},   32'(o_out),       32'h0);
    chk({tag, "_err"},   32'(o_ERR),       32'h0);
    chk({tag, "_valid"}, 32'(o_valid),     32'h0);
    chk({tag, "_ready"}, 32'(o_ready),     32'h1);
    chk({tag, "_state"}, 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] exp_out;
    logic         exp_err;
    int           lat;
  } vec_t;

  vec_t vecs[10];
  logic [N-1:0] r_eo;
  logic         r_ee;
  int           r_lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b00, 8'h00, 8'h03, 8'h00, 8'h08, 1'b0, 1};
    vecs[1] = '{2'b01, 8'hFF, 8'h07, 8'h00, 8'h7F, 1'b0, 1};
    vecs[2] = '{2'b10, 8'h0F, 8'h00, 8'h00, 8'h0E, 1'b0, 1};
    vecs[3] = '{2'b00, 8'h10, 8'h01, 8'hFF, 8'h12, 1'b0, 1};
    vecs[4] = '{2'b00, 8'h55, 8'h83, 8'h00, 8'h00, 1'b1, 1};
    vecs[5] = '{2'b01, 8'h55, 8'h08, 8'h00, 8'h00, 1'b1, 1};
    vecs[6] = '{2'b11, 8'h00, 8'h05, 8'h02, 8'h00, 1'b1, 1};
    vecs[7] = '{2'b11, 8'h00, 8'h02, 8'h05, 8'h3C, 1'b0, 5};
    vecs[8] = '{2'b11, 8'hA0, 8'h03, 8'h03, 8'hA8, 1'b0, 2};
    vecs[9] = '{2'b11, 8'h00, 8'h00, 8'h87, 8'h00, 1'b1, 1};

    in_rst_n = 1'b0;
    in_valid = 1'b0;
    in_mode  = 2'b00;
    in_a     = '0;
    in_b     = '0;
    in_c     = '0;
    repeat (3) @(negedge in_clk);
    chk_reset_vals("rst_held");
    in_rst_n = 1'b1;
    @(negedge in_clk);
    chk_reset_vals("rst_rel");

    // Table: first three are back-to-back single-bit ops.
    for (int i = 0; i < 10; i++)
      send(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_out, vecs[i].exp_err, vecs[i].lat);
    go_idle();
    drain("table_drain");

    // Range with a stray request during RUN; ready low for exactly four cycles.
    send(2'b11, 8'h00, 8'h02, 8'h05, 8'h3C, 1'b0, 5);
    for (int k = 0; k < 5; k++) begin
      @(negedge in_clk);
      if (k == 0) begin
        in_valid = 1'b1;
        in_mode  = 2'b00;
        in_a     = 8'hFF;
        in_b     = 8'h00;
      end else begin
        in_valid = 1'b0;
      end
      chk("run_ready", 32'(o_ready), (k < 4) ? 32'd0 : 32'd1);
    end
    drain("run_drain");
    @(negedge in_clk);
    chk("held_out", 32'(o_out), 32'h3C);
    chk("held_valid", 32'(o_valid), 32'h0);

    // Reset during the third RUN cycle aborts the range.
    send(2'b11, 8'h81, 8'h01, 8'h06, 8'hFF, 1'b0, 7);
    @(negedge in_clk);
    in_valid = 1'b0;
    chk("abort_state_run", 32'(o_dbg_state), 32'(ST_RUN));
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals("abort");
    @(negedge in_clk);
    in_rst_n = 1'b1;
    repeat (10) @(negedge in_clk);
    chk_reset_vals("abort_quiet");
    send(2'b00, 8'h00, 8'h01, 8'h00, 8'h02, 1'b0, 1);
    go_idle();
    drain("post_abort_drain");

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      send_rand();
    end
    go_idle();
    drain("rand_drain");

    model(2'b10, 8'hF0, 8'h04, 8'h00, r_eo, r_ee, r_lat);
    send(2'b10, 8'hF0, 8'h04, 8'h00, r_eo, r_ee, r_lat);
    go_idle();
    drain("final_drain");
    repeat (2) @(negedge in_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
